// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake and adder-side bus for the sequential
// shift-add multiplier. The adder itself stays outside the multiplier.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     add_x;
  logic [WIDTH-1:0]     add_y;
  logic                 add_cin;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  // Requester + adder side: drives operands and the adder result.
  modport master (
    output start, a, b, add_sum, add_cout,
    input  add_x, add_y, add_cin, busy, done, product
  );

  // Multiplier side.
  modport slave (
    input  start, a, b, add_sum, add_cout,
    output add_x, add_y, add_cin, busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier, one shift-add step per clock, using an
// external combinational adder for the accumulate step.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | eight shift-add iterations, adder result folded into {A,Q}
// DONE  | one-cycle done pulse, product valid; start ignored
//
// Only WIDTH = 8 is supported: the iteration counter and the external
// adder are both sized for eight bits.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_add_multiplier_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     reg_m;
  logic [WIDTH-1:0]     reg_a;
  logic [WIDTH-1:0]     reg_q;
  logic [2:0]           cnt;
  logic [2*WIDTH-1:0]   product_q;
  logic                 busy_c;
  logic                 done_c;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy_c = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, shift-add iteration and product latch. The adder
  // result is only consumed in RUN, so its don't-care value elsewhere
  // never reaches any register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_m     <= '0;
      reg_a     <= '0;
      reg_q     <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            reg_m <= bus.a;
            reg_q <= bus.b;
            reg_a <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          reg_a <= {bus.add_cout, bus.add_sum[WIDTH-1:1]};
          reg_q <= {bus.add_sum[0], reg_q[WIDTH-1:1]};
          cnt   <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            product_q <= {bus.add_cout, bus.add_sum, reg_q[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Adder operands follow the registers in every state; carry-in unused.
  assign bus.add_x   = reg_a;
  assign bus.add_y   = reg_q[0] ? reg_m : '0;
  assign bus.add_cin = 1'b0;

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for the shift-add multiplier with a behavioural 8-bit adder in
// the loop. Table-driven products plus hand sequences for start-ignore,
// mid-run reset and back-to-back operation.
module tb_shift_add_multiplier;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] prev_prod;

  shift_add_multiplier_if #(.WIDTH(8)) bus ();

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // External combinational adder.
  assign {bus.add_cout, bus.add_sum} =
    {1'b0, bus.add_x} + {1'b0, bus.add_y} + {8'h00, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One operation: accept at E0, then check each cycle after edges 1..11.
  // With inject set, start is pulsed with other operands in RUN and DONE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit inject);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'h55;
    bus.b     = 8'h55;
    chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      chk("busy", {31'b0, bus.busy}, {31'b0, (k <= 8)});
      chk("done", {31'b0, bus.done}, {31'b0, (k == 8)});
      chk("add_cin", {31'b0, bus.add_cin}, 32'd0);
      chk("product", {16'b0, bus.product}, {16'b0, (k >= 8) ? exp : prev_prod});
      if (inject) begin
        bus.start = (k == 3) || (k == 8);
      end
    end
    bus.start = 1'b0;
    prev_prod = exp;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    prev_prod = 16'h0000;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h12, 8'h34, 16'h03A8};
    vecs[5] = '{8'h01, 8'h01, 16'h0001};
    vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[7] = '{8'hA5, 8'h3C, 16'h26AC};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_product", {16'b0, bus.product}, 32'd0);
    chk("rst_add_x", {24'b0, bus.add_x}, 32'd0);
    chk("rst_add_y", {24'b0, bus.add_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    // Start pulses in RUN and DONE must be ignored.
    run_op(8'h0D, 8'h0B, 16'h008F, 1'b1);

    // Reset mid-run: sampled at RUN edge 4.
    @(negedge clk);
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    chk("midrst_product", {16'b0, bus.product}, 32'd0);
    chk("midrst_add_x", {24'b0, bus.add_x}, 32'd0);
    chk("midrst_add_y", {24'b0, bus.add_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_done", {31'b0, bus.done}, 32'd0);
      chk("midrst_idle", {31'b0, bus.busy}, 32'd0);
    end
    prev_prod = 16'h0000;
    run_op(8'h12, 8'h34, 16'h03A8, 1'b0);

    // Back-to-back with start held: second accept at E10, done after E18.
    @(negedge clk);
    bus.a     = 8'h0D;
    bus.b     = 8'h0B;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h03;
    bus.b = 8'h07;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      #1;
      chk("b2b_busy", {31'b0, bus.busy}, {31'b0, (k <= 8) || (k >= 10 && k <= 18)});
      chk("b2b_done", {31'b0, bus.done}, {31'b0, (k == 8) || (k == 18)});
      chk("b2b_product", {16'b0, bus.product},
          {16'b0, (k < 8) ? 16'h03A8 : (k < 18) ? 16'h008F : 16'h0015});
      if (k == 18) bus.start = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
